// File: rtl/vga_overlay_pkg.sv
// Shared types and default colours for the VGA selection overlay.
package vga_overlay_pkg;

  typedef logic [23:0] color_t;

  typedef enum logic {
    VISIBLE = 1'b0,
    HIDDEN  = 1'b1
  } blink_state_e;

  localparam color_t COLOR_A_DEF = 24'h82C3CA;
  localparam color_t COLOR_B_DEF = 24'hB70000;

endpackage

// File: rtl/slc_grid_overlay_blink_timer.sv
// Frame-based blink FSM: toggles VISIBLE/HIDDEN every BLINK_FRAMES frame ticks.
module blink_timer
  import vga_overlay_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic blink_en,
  output logic visible
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  blink_state_e  state_q, state_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VISIBLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!blink_en) begin
      state_d = VISIBLE;
      fcnt_d  = '0;
    end else if (frame_tick) begin
      if (fcnt_q == LAST) begin
        fcnt_d  = '0;
        state_d = (state_q == VISIBLE) ? HIDDEN : VISIBLE;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    visible = (state_q == VISIBLE);
  end

endmodule

// File: rtl/slc_grid_overlay.sv
// Grid selection-highlight overlay: per-row/column bound compares, per-frame
// selection buffer, optional blink, two-stage output pipeline.
module slc_grid_overlay
  import vga_overlay_pkg::*;
#(
  parameter int unsigned NCOLS        = 2,
  parameter int unsigned NROWS        = 2,
  parameter int unsigned H_ORIGIN     = 141,
  parameter int unsigned V_ORIGIN     = 38,
  parameter int unsigned CELL_W       = 308,
  parameter int unsigned CELL_H       = 235,
  parameter int unsigned H_GAP        = 6,
  parameter int unsigned V_GAP        = 6,
  parameter color_t      COLOR_A      = COLOR_A_DEF,
  parameter color_t      COLOR_B      = COLOR_B_DEF,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned SEL_W        = $clog2(NCOLS*NROWS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             win,
  input  logic             blink_en,
  input  logic [SEL_W-1:0] isel,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  output color_t           ocolor,
  output logic             slc_on
);

  localparam int unsigned NCELLS = NCOLS * NROWS;

  logic [31:0]       hx, vy;
  logic [NCOLS-1:0]  col_hit_d, col_hit_q;
  logic [NROWS-1:0]  row_hit_d, row_hit_q;
  logic              win_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NCELLS-1:0] cell_hit, cell_odd;
  logic              visible;
  logic              slc_on_d, slc_on_q;
  color_t            ocolor_d, ocolor_q;

  assign hx = {22'd0, hcount};
  assign vy = {22'd0, vcount};

  for (genvar c = 0; c < NCOLS; c++) begin : g_col
    localparam logic [31:0] XLO = 32'(H_ORIGIN + c * (CELL_W + H_GAP));
    localparam logic [31:0] XHI = XLO + 32'(CELL_W - 1);
    assign col_hit_d[c] = (hx >= XLO) && (hx <= XHI);
  end

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    localparam logic [31:0] YLO = 32'(V_ORIGIN + r * (CELL_H + V_GAP));
    localparam logic [31:0] YHI = YLO + 32'(CELL_H - 1);
    assign row_hit_d[r] = (vy >= YLO) && (vy <= YHI);
  end

  // Selection outside 1..NCELLS matches no cell index, so it reads as "none".
  for (genvar r = 0; r < NROWS; r++) begin : g_cell_r
    for (genvar c = 0; c < NCOLS; c++) begin : g_cell_c
      localparam int unsigned IDX = r * NCOLS + c;
      localparam logic        ODD = 1'((r + c) % 2);
      assign cell_hit[IDX] = row_hit_q[r] & col_hit_q[c] & (sel_q == SEL_W'(IDX + 1));
      assign cell_odd[IDX] = cell_hit[IDX] & ODD;
    end
  end

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .blink_en  (blink_en),
    .visible   (visible)
  );

  always_comb begin
    slc_on_d = (|cell_hit) & ~win_q & visible;
    ocolor_d = ocolor_q;
    if (slc_on_d) begin
      ocolor_d = (|cell_odd) ? COLOR_B : COLOR_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      col_hit_q <= '0;
      row_hit_q <= '0;
      win_q     <= 1'b0;
      slc_on_q  <= 1'b0;
      ocolor_q  <= '0;
    end else begin
      if (frame_tick) begin
        sel_q <= isel;
      end
      col_hit_q <= col_hit_d;
      row_hit_q <= row_hit_d;
      win_q     <= win;
      slc_on_q  <= slc_on_d;
      ocolor_q  <= ocolor_d;
    end
  end

  assign slc_on = slc_on_q;
  assign ocolor = ocolor_q;

endmodule

// File: tb/tb_slc_grid_overlay.sv
// Directed bench for slc_grid_overlay (default geometry, BLINK_FRAMES=2).
module tb_slc_grid_overlay;

  localparam logic [23:0] CA = 24'h82C3CA;
  localparam logic [23:0] CB = 24'hB70000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        win;
  logic        blink_en;
  logic [2:0]  isel;
  logic [9:0]  hcount, vcount;
  logic [23:0] ocolor;
  logic        slc_on;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slc_grid_overlay #(
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .win       (win),
    .blink_en  (blink_en),
    .isel      (isel),
    .hcount    (hcount),
    .vcount    (vcount),
    .ocolor    (ocolor),
    .slc_on    (slc_on)
  );

  typedef struct {
    logic [2:0]  isel;
    bit          tick;
    logic [9:0]  hc;
    logic [9:0]  vc;
    bit          win;
    bit          exp_on;
    bit          chk_col;
    logic [23:0] exp_col;
  } vec_t;

  vec_t vecs[22];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_px(input int x, input int y);
    hcount = 10'(x);
    vcount = 10'(y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'd1, 1'b1, 10'd141, 10'd38,  1'b0, 1'b1, 1'b1, CA};
    vecs[1]  = '{3'd1, 1'b0, 10'd448, 10'd272, 1'b0, 1'b1, 1'b1, CA};
    vecs[2]  = '{3'd1, 1'b0, 10'd449, 10'd100, 1'b0, 1'b0, 1'b0, CA};
    vecs[3]  = '{3'd1, 1'b0, 10'd140, 10'd38,  1'b0, 1'b0, 1'b0, CA};
    vecs[4]  = '{3'd1, 1'b0, 10'd141, 10'd37,  1'b0, 1'b0, 1'b0, CA};
    vecs[5]  = '{3'd2, 1'b1, 10'd455, 10'd38,  1'b0, 1'b1, 1'b1, CB};
    vecs[6]  = '{3'd2, 1'b0, 10'd452, 10'd38,  1'b0, 1'b0, 1'b0, CB};
    vecs[7]  = '{3'd2, 1'b0, 10'd762, 10'd272, 1'b0, 1'b1, 1'b1, CB};
    vecs[8]  = '{3'd2, 1'b0, 10'd763, 10'd272, 1'b0, 1'b0, 1'b0, CB};
    vecs[9]  = '{3'd2, 1'b0, 10'd141, 10'd38,  1'b0, 1'b0, 1'b0, CB};
    vecs[10] = '{3'd4, 1'b1, 10'd455, 10'd279, 1'b0, 1'b1, 1'b1, CA};
    vecs[11] = '{3'd4, 1'b0, 10'd762, 10'd513, 1'b0, 1'b1, 1'b1, CA};
    vecs[12] = '{3'd4, 1'b0, 10'd762, 10'd514, 1'b0, 1'b0, 1'b0, CA};
    vecs[13] = '{3'd4, 1'b0, 10'd455, 10'd278, 1'b0, 1'b0, 1'b0, CA};
    vecs[14] = '{3'd3, 1'b1, 10'd141, 10'd279, 1'b0, 1'b1, 1'b1, CB};
    vecs[15] = '{3'd3, 1'b0, 10'd448, 10'd513, 1'b0, 1'b1, 1'b1, CB};
    vecs[16] = '{3'd3, 1'b0, 10'd141, 10'd279, 1'b1, 1'b0, 1'b0, CB};
    vecs[17] = '{3'd3, 1'b0, 10'd141, 10'd38,  1'b0, 1'b0, 1'b0, CB};
    vecs[18] = '{3'd5, 1'b1, 10'd141, 10'd38,  1'b0, 1'b0, 1'b0, CB};
    vecs[19] = '{3'd5, 1'b0, 10'd455, 10'd279, 1'b0, 1'b0, 1'b0, CB};
    vecs[20] = '{3'd0, 1'b1, 10'd141, 10'd38,  1'b0, 1'b0, 1'b0, CB};
    vecs[21] = '{3'd0, 1'b0, 10'd455, 10'd38,  1'b0, 1'b0, 1'b0, CB};

    rst_n = 1'b0; frame_tick = 1'b0; win = 1'b0; blink_en = 1'b0;
    isel = '0; hcount = '0; vcount = '0;
    step(2);
    check("reset_slc_on", {23'd0, slc_on}, 24'd0);
    check("reset_ocolor", ocolor, 24'd0);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 22; i++) begin
      isel = vecs[i].isel;
      if (vecs[i].tick) tick();
      set_px(int'(vecs[i].hc), int'(vecs[i].vc));
      win = vecs[i].win;
      step(2);
      check($sformatf("vec%0d_slc_on", i), {23'd0, slc_on}, {23'd0, vecs[i].exp_on});
      if (vecs[i].chk_col)
        check($sformatf("vec%0d_ocolor", i), ocolor, vecs[i].exp_col);
    end
    win = 1'b0;

    // Mid-frame selection change only lands on the next tick.
    isel = 3'd3; tick();
    set_px(141, 279); step(2);
    check("midframe_cell3_on", {23'd0, slc_on}, 24'd1);
    isel = 3'd4; step(3);
    check("midframe_cell3_held", {23'd0, slc_on}, 24'd1);
    set_px(455, 279); step(2);
    check("midframe_cell4_before_tick", {23'd0, slc_on}, 24'd0);
    tick(); step(2);
    check("midframe_cell4_after_tick", {23'd0, slc_on}, 24'd1);
    check("midframe_cell4_color", ocolor, CA);
    set_px(141, 279); step(2);
    check("midframe_cell3_after_tick", {23'd0, slc_on}, 24'd0);

    // win suppresses exactly two clocks after it rises.
    set_px(455, 279); step(2);
    check("win_pre", {23'd0, slc_on}, 24'd1);
    win = 1'b1; step(1);
    check("win_lat1", {23'd0, slc_on}, 24'd1);
    step(1);
    check("win_lat2", {23'd0, slc_on}, 24'd0);
    win = 1'b0; step(2);
    check("win_release", {23'd0, slc_on}, 24'd1);

    // Blink with BLINK_FRAMES=2: per-frame pattern 1,1,0,0,1,1.
    blink_en = 1'b1; step(2);
    check("blink_frame0", {23'd0, slc_on}, 24'd1);
    begin
      bit exp_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int f = 0; f < 5; f++) begin
        tick(); step(3);
        check($sformatf("blink_frame%0d", f + 1), {23'd0, slc_on}, {23'd0, exp_pat[f]});
      end
    end
    tick(); step(3);
    check("blink_hidden", {23'd0, slc_on}, 24'd0);
    blink_en = 1'b0;
    begin
      int k = 0;
      while (slc_on !== 1'b1 && k < 3) begin
        step(1);
        k++;
      end
    end
    check("blink_fall_visible", {23'd0, slc_on}, 24'd1);
    blink_en = 1'b1; step(2);
    check("blink_rise_no_tick", {23'd0, slc_on}, 24'd1);
    tick(); step(2);
    check("blink_rise_tick1", {23'd0, slc_on}, 24'd1);
    tick(); step(2);
    check("blink_rise_tick2", {23'd0, slc_on}, 24'd0);
    blink_en = 1'b0; step(3);
    check("blink_off_again", {23'd0, slc_on}, 24'd1);

    // Asynchronous reset mid-frame, then wait for a tick to reload selection.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_slc_on", {23'd0, slc_on}, 24'd0);
    check("async_rst_ocolor", ocolor, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("post_rst_no_tick", {23'd0, slc_on}, 24'd0);
    step(4);
    check("post_rst_no_tick_later", {23'd0, slc_on}, 24'd0);
    tick(); step(2);
    check("post_rst_after_tick", {23'd0, slc_on}, 24'd1);
    check("post_rst_color", ocolor, CA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
